// File: rtl/jogo_unidade_controle.sv
// Control unit (Moore FSM) for the memory-sequence game: sequences play capture, comparison and address stepping.
// Optional play timeout is enabled by defining TIMEOUT_EN; the default build waits for jogada indefinitely.
module jogo_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fimC,
    input  logic       igual,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t r_estado;
    estado_t w_proximo;
    logic    w_expira;

`ifdef TIMEOUT_EN
    localparam int            CW    = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] C_MAX = CW'(TIMEOUT_CICLOS - 1);

    logic [CW-1:0] r_cnt;

    // Cleared in every other state so it is always 0 on entry to espera; saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || (r_estado != ESPERA)) begin
            r_cnt <= '0;
        end else if (r_cnt != C_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_expira = (r_estado == ESPERA) && (r_cnt == C_MAX);
`else
    assign w_expira = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // NOTE: default assigned first so no path leaves w_proximo unassigned (no latch).
    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:     w_proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  w_proximo = ESPERA;
            ESPERA: begin
                if (jogada) begin
                    w_proximo = REGISTRA;
                end else if (w_expira) begin
                    w_proximo = FIM_TIMEOUT;
                end else begin
                    w_proximo = ESPERA;
                end
            end
            REGISTRA:    w_proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    w_proximo = FIM_ERRO;
                end else if (fimC) begin
                    w_proximo = FIM_ACERTO;
                end else begin
                    w_proximo = PROXIMO;
                end
            end
            PROXIMO:     w_proximo = ESPERA;
            FIM_ACERTO,
            FIM_TIMEOUT,
            FIM_ERRO:    w_proximo = iniciar ? PREPARACAO : r_estado;
            default:     w_proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = 4'hF;
        case (r_estado)
            INICIAL: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
                db_estado = 4'h0;
            end
            PREPARACAO: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
                db_estado = 4'h1;
            end
            ESPERA:      db_estado = 4'h3;
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = 4'h4;
            end
            COMPARACAO:  db_estado = 4'h5;
            PROXIMO: begin
                contaC    = 1'b1;
                db_estado = 4'h6;
            end
            FIM_ACERTO: begin
                pronto    = 1'b1;
                acertou   = 1'b1;
                db_estado = 4'hA;
            end
            FIM_TIMEOUT: begin
                pronto    = 1'b1;
                errou     = 1'b1;
`ifdef TIMEOUT_EN
                timeout   = 1'b1;
`endif
                db_estado = 4'hD;
            end
            FIM_ERRO: begin
                pronto    = 1'b1;
                errou     = 1'b1;
                db_estado = 4'hE;
            end
            default:     db_estado = 4'hF;
        endcase
    end

endmodule
